// File: rtl/evil_pkg.sv
// Shared constants and FSM encoding for the evil_sink data path.
// Z is the root constant. A and B are derived from it, so they stay consistent when Z changes.
package evil_pkg;

  localparam int unsigned evil_pkg_Z     = 1;
  localparam int unsigned evil_pkg_A     = evil_pkg_Z;
  localparam int unsigned evil_pkg_B     = evil_pkg_Z;
  localparam int unsigned evil_pkg_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/evil_sink_mem.sv
// DEPTH x WIDTH storage with one write port and a registered read of the FIFO head.
// A write to the address being read is forwarded, so a word entering an empty FIFO shows up the next cycle.
import evil_pkg::*;

module evil_sink_mem #(
  parameter int unsigned WIDTH = evil_pkg_B,
  parameter int unsigned DEPTH = evil_pkg_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)                       rdata <= '0;
    else if (we && waddr == raddr) rdata <= wdata;
    else                           rdata <= mem[raddr];
  end

endmodule

// File: rtl/evil_sink.sv
// FIFO sink that checks each accepted word against EXPECT, counts matches and flags mismatches.
// Optional macro EVIL_SINK_HALT_EN: the first mismatching push halts input acceptance until rst.
import evil_pkg::*;

module evil_sink #(
  parameter int unsigned WIDTH  = evil_pkg_B,
  parameter int unsigned EXPECT = evil_pkg_A,
  parameter int unsigned DEPTH  = evil_pkg_DEPTH,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] match_cnt,
  output logic             mismatch,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [WIDTH-1:0] EXP_W = WIDTH'(EXPECT);

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_nxt;
  logic          push;
  logic          pop;
  logic          hit;
  logic          halt_nxt;

  // Handshakes and next occupancy. The registered flags are built from these next values.
  always_comb begin
    push    = in_valid && in_ready;
    pop     = out_valid && out_ready;
    hit     = (in_data == EXP_W);
    rd_nxt  = pop ? rd_ptr + PW'(1) : rd_ptr;
    cnt_nxt = count;
    if (push && !pop)      cnt_nxt = count + CW'(1);
    else if (pop && !push) cnt_nxt = count - CW'(1);
`ifdef EVIL_SINK_HALT_EN
    halt_nxt = (state == HALT) || (push && !hit);
`else
    halt_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      match_cnt <= '0;
      mismatch  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      if (push && hit && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
      if (push && !hit) mismatch <= 1'b1;
      full      <= (cnt_nxt == CW'(DEPTH));
      empty     <= (cnt_nxt == '0);
      out_valid <= (cnt_nxt != '0);
      in_ready  <= (cnt_nxt != CW'(DEPTH)) && !halt_nxt;
      case (state)
        IDLE:    if (push) state <= BUSY;
        BUSY:    if (cnt_nxt == '0) state <= IDLE;
        default: state <= state;
      endcase
`ifdef EVIL_SINK_HALT_EN
      if (halt_nxt) state <= HALT;
`endif
    end
  end

  evil_sink_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_nxt),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_evil_sink.sv
// Bench for evil_sink: default instance (table + random vs queue model) and WIDTH=4/EXPECT=5/CNT_W=2 instance.
// Expectations follow EVIL_SINK_HALT_EN when it is defined.
`timescale 1ns/1ps

module tb_evil_sink;

`ifdef EVIL_SINK_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_iv = 1'b0, a_ordy = 1'b0;
  logic [0:0] a_id = '0;
  logic       a_ir, a_ov, a_mm, a_full, a_empty;
  logic [0:0] a_od;
  logic [7:0] a_mc;

  logic       b_rst = 1'b1, b_iv = 1'b0, b_ordy = 1'b0;
  logic [3:0] b_id = '0;
  logic       b_ir, b_ov, b_mm, b_full, b_empty;
  logic [3:0] b_od;
  logic [1:0] b_mc;

  evil_sink u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od), .match_cnt(a_mc),
    .mismatch(a_mm), .full(a_full), .empty(a_empty)
  );

  evil_sink #(.WIDTH(4), .EXPECT(5), .DEPTH(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od), .match_cnt(b_mc),
    .mismatch(b_mm), .full(b_full), .empty(b_empty)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model of instance A: contents as a queue, plus counters.
  logic m_q[$];
  int   m_cnt  = 0;
  bit   m_mm   = 1'b0;
  bit   m_halt = 1'b0;

  task automatic tick_a();
    bit push, pop;
    @(posedge clk);
    if (a_rst) begin
      m_q.delete(); m_cnt = 0; m_mm = 1'b0; m_halt = 1'b0;
    end else begin
      push = a_iv && (m_q.size() < 4) && !m_halt;
      pop  = a_ordy && (m_q.size() > 0);
      if (push) begin
        if (a_id == 1'b1) begin
          if (m_cnt < 255) m_cnt++;
        end else begin
          m_mm = 1'b1;
          if (HALT_EN) m_halt = 1'b1;
        end
      end
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(a_id[0]);
    end
    #1;
    chk("a_empty", int'(a_empty), int'(m_q.size() == 0));
    chk("a_full", int'(a_full), int'(m_q.size() == 4));
    chk("a_out_valid", int'(a_ov), int'(m_q.size() != 0));
    chk("a_in_ready", int'(a_ir), int'(m_q.size() < 4 && !m_halt));
    chk("a_match_cnt", int'(a_mc), m_cnt);
    chk("a_mismatch", int'(a_mm), int'(m_mm));
    if (m_q.size() != 0) chk("a_out_data", int'(a_od), int'(m_q[0]));
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, iv, id, ordy;
    logic e_empty, e_full, e_ir, e_ov, chk_od, e_od;
    int   e_mc;
    logic e_mm;
  } vec_t;

  function automatic vec_t mk(logic rst, logic iv, logic id, logic ordy, logic e_empty,
                              logic e_full, logic e_ir, logic e_ov, logic chk_od,
                              logic e_od, int e_mc, logic e_mm);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_empty = e_empty; v.e_full = e_full; v.e_ir = e_ir; v.e_ov = e_ov;
    v.chk_od = chk_od; v.e_od = e_od; v.e_mc = e_mc; v.e_mm = e_mm;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    //             rst iv id rdy  emp ful ir       ov  chk od mc mm
    tbl[0]  = mk(1, 0, 0, 0,   1,  0,  1,        0,  1,  0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0,   0,  0,  1,        1,  1,  1, 1, 0);
    tbl[2]  = mk(0, 1, 1, 0,   0,  0,  1,        1,  1,  1, 2, 0);
    tbl[3]  = mk(0, 1, 1, 0,   0,  0,  1,        1,  1,  1, 3, 0);
    tbl[4]  = mk(0, 1, 1, 0,   0,  1,  0,        1,  1,  1, 4, 0);
    tbl[5]  = mk(0, 1, 1, 0,   0,  1,  0,        1,  1,  1, 4, 0);
    tbl[6]  = mk(0, 1, 1, 1,   0,  0,  1,        1,  1,  1, 4, 0);
    tbl[7]  = mk(0, 1, 0, 1,   0,  0,  !HALT_EN, 1,  1,  1, 4, 1);
    tbl[8]  = mk(0, 0, 0, 1,   0,  0,  !HALT_EN, 1,  1,  1, 4, 1);
    tbl[9]  = mk(0, 0, 0, 1,   0,  0,  !HALT_EN, 1,  1,  0, 4, 1);
    tbl[10] = mk(0, 0, 0, 1,   1,  0,  !HALT_EN, 0,  0,  0, 4, 1);
    tbl[11] = mk(1, 1, 1, 1,   1,  0,  1,        0,  1,  0, 0, 0);

    // Instance A: directed table.
    for (int i = 0; i < 12; i++) begin
      a_rst = tbl[i].rst; a_iv = tbl[i].iv; a_id = tbl[i].id; a_ordy = tbl[i].ordy;
      tick_a();
      chk($sformatf("tbl%0d_empty", i), int'(a_empty), int'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_full", i), int'(a_full), int'(tbl[i].e_full));
      chk($sformatf("tbl%0d_in_ready", i), int'(a_ir), int'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), int'(a_ov), int'(tbl[i].e_ov));
      if (tbl[i].chk_od) chk($sformatf("tbl%0d_out_data", i), int'(a_od), int'(tbl[i].e_od));
      chk($sformatf("tbl%0d_match_cnt", i), int'(a_mc), tbl[i].e_mc);
      chk($sformatf("tbl%0d_mismatch", i), int'(a_mm), int'(tbl[i].e_mm));
    end

    // Instance A: random traffic against the queue model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      a_rst  = ($urandom_range(0, 49) == 0);
      a_iv   = ($urandom_range(0, 3) != 0);
      a_id   = 1'($urandom_range(0, 7) != 0);
      a_ordy = 1'($urandom_range(0, 1));
      tick_a();
    end
    a_rst = 1'b1; a_iv = 1'b0;
    tick_a();

    // Instance B: push 5 then 3.
    b_rst = 1'b1; tick_b();
    chk("b_rst_empty", int'(b_empty), 1);
    chk("b_rst_out_data", int'(b_od), 0);
    b_rst = 1'b0; b_iv = 1'b1; b_id = 4'd5; b_ordy = 1'b0; tick_b();
    chk("b_push5_mc", int'(b_mc), 1);
    chk("b_push5_od", int'(b_od), 5);
    b_id = 4'd3; tick_b();
    chk("b_push3_mc", int'(b_mc), 1);
    chk("b_push3_mm", int'(b_mm), 1);
    chk("b_head", int'(b_od), 5);
`ifdef EVIL_SINK_HALT_EN
    chk("b_halt_in_ready", int'(b_ir), 0);
    b_id = 4'd5; b_ordy = 1'b1; tick_b();
    chk("b_halt_drain1", int'(b_od), 3);
    chk("b_halt_mc", int'(b_mc), 1);
    chk("b_halt_in_ready2", int'(b_ir), 0);
    tick_b();
    chk("b_halt_drain_empty", int'(b_empty), 1);
`else
    chk("b_in_ready", int'(b_ir), 1);
    b_id = 4'd5; tick_b();
    chk("b_third_mc", int'(b_mc), 2);
    chk("b_third_mm", int'(b_mm), 1);
    b_iv = 1'b0; b_ordy = 1'b1; tick_b();
    chk("b_drain1", int'(b_od), 3);
    tick_b();
    chk("b_drain2", int'(b_od), 5);
    tick_b();
    chk("b_drain_empty", int'(b_empty), 1);
`endif

    // Instance B: match counter saturates at 3.
    b_rst = 1'b1; b_iv = 1'b0; tick_b();
    b_rst = 1'b0; b_iv = 1'b1; b_id = 4'd5; b_ordy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick_b();
      chk($sformatf("b_sat%0d_mc", k), int'(b_mc), (k + 1 > 3) ? 3 : k + 1);
    end

    // Instance B: reset with two words buffered and push/pop both active.
    b_rst = 1'b1; b_iv = 1'b0; tick_b();
    b_rst = 1'b0; b_iv = 1'b1; b_ordy = 1'b0; b_id = 4'd5; tick_b();
    b_id = 4'd3; tick_b();
    chk("b_pre_rst_empty", int'(b_empty), 0);
    chk("b_pre_rst_mm", int'(b_mm), 1);
    b_rst = 1'b1; b_iv = 1'b1; b_ordy = 1'b1; b_id = 4'd5; tick_b();
    chk("b_mid_rst_empty", int'(b_empty), 1);
    chk("b_mid_rst_mc", int'(b_mc), 0);
    chk("b_mid_rst_mm", int'(b_mm), 0);
    chk("b_mid_rst_in_ready", int'(b_ir), 1);
    chk("b_mid_rst_out_valid", int'(b_ov), 0);
    chk("b_mid_rst_out_data", int'(b_od), 0);
    b_rst = 1'b0; b_iv = 1'b0; b_ordy = 1'b0; tick_b();
    chk("b_post_rst_empty", int'(b_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
